game_round_ctrl: RTL and testbench
==================================

# game_round_ctrl

Parametrised single-clock game-round controller. It is the successor to the fixed 15 s, 4-digit period block: period length, digit count, symbol width and counter width are generics, the 1 Hz domain is replaced by an internal prescaler, and a player-answer check phase is added. It sits between the start button logic, the symbol generator and the seven-segment driver.

## Interface

- CLK_HZ, 100_000_000: Clk100M frequency; sets the prescaler terminal count.
- PERIOD_SEC, 15: round length in seconds, at least 1.
- SEG_COUNT, 4: number of displayed symbol digits, at least 1.
- SYM_W, 8: symbol/segment pattern width.
- CNT_W, 8: width of the special counter and the answer.
- SEG_BLANK, 8'h01: digit value after clear. Width is SYM_W.
- Clk100M, input, 1: sole clock. All logic is on its rising edge.
- Rst, input, 1: synchronous, active-high reset.
- gameSig, input, 1: one-cycle start request.
- symValid, input, 1: one-cycle strobe from the symbol generator.
- symSpecial, input, 1: qualifies symValid; the symbol is special.
- symData, input, SYM_W: the generated symbol.
- answerValid, input, 1: player answer strobe.
- answerVal, input, CNT_W: the player's count.
- startGen, output, 1: one-cycle pulse at round start.
- stopGen, output, 1: one-cycle pulse at round end.
- answerSig, output, 1: high while an answer is awaited.
- resultValid, output, 1: one-cycle pulse when an answer is judged.
- resultOk, output, 1: answerVal equalled numSpecial. Held until the next resultValid.
- numSpecial, output, CNT_W: special symbols this round.
- timeLeft, output, $clog2(PERIOD_SEC+1): whole seconds remaining.
- gameSegs, output, SEG_COUNT*SYM_W: digit 0 is in the LSBs and holds the newest symbol.

## Operation

- States:
  - IDLE: the only state reachable by reset.
  - RUN: the round is being timed.
  - ANSWER: waiting for the player's count.
- Reset values:
  - state = IDLE.
  - All pulse outputs, answerSig and resultOk are 0.
  - numSpecial = 0 and timeLeft = 0.
  - Every digit = SEG_BLANK.
  - Prescaler = 0.
- IDLE, gameSig = 1:
  - Go to RUN.
  - numSpecial and prescaler are cleared.
  - timeLeft is loaded with PERIOD_SEC.
  - All digits are set to SEG_BLANK.
  - startGen pulses.
- RUN:
  - The prescaler counts 0 to CLK_HZ-1, then wraps. On wrap, timeLeft decrements.
  - When the decrement brings timeLeft to 0, go to ANSWER. stopGen pulses and answerSig rises.
- RUN, symValid = 1:
  - The digits shift: digit i takes digit i-1, and digit 0 takes symData. The oldest digit is discarded.
  - If symSpecial = 1, numSpecial increments.
  - numSpecial saturates at 2^CNT_W-1 and does not wrap.
- ANSWER, answerValid = 1:
  - resultOk is set to (answerVal == numSpecial).
  - resultValid pulses and answerSig falls. Go to IDLE.
- Ignored inputs:
  - gameSig in RUN or ANSWER.
  - symValid outside RUN.
  - answerValid outside ANSWER.
- Held values: numSpecial and the digits are not changed in IDLE, so they stay visible after the round.
- Rst in any state overrides every other input and returns all outputs to their reset values in the next cycle.

## Timing

- gameSig sampled at edge N: startGen is high during cycle N+1, and state = RUN in that cycle.
- RUN lasts exactly PERIOD_SEC*CLK_HZ cycles. stopGen is high in the first ANSWER cycle.
- symValid in the final RUN cycle is accepted. symValid in the first ANSWER cycle is dropped.
- Digits and numSpecial update one cycle after symValid.
- answerValid at edge M: resultValid and resultOk are visible in cycle M+1, and state = IDLE in that cycle.
- gameSig in that same IDLE cycle is accepted, so back-to-back rounds are legal.

## Configuration

- GAME_ROUND_PAUSE_EN defined:
  - Adds input pause (1 bit) and output genHold (1 bit).
  - In RUN with pause = 1:
    - The prescaler and timeLeft freeze.
    - symValid is ignored.
    - genHold = 1 (combinational from pause and state).
  - The round is lengthened by the number of paused cycles.
  - pause has no effect in other states.
- Undefined: the pause and genHold ports do not exist, and behaviour is identical to pause = 0.

## Structure

- Package game_pkg holds:
  - the state enum (IDLE, RUN, ANSWER);
  - the SEG_BLANK default constant;
  - a helper function for the timeLeft width.
- One sub-module, game_prescaler:
  - Parameter: CLK_HZ. Inputs: clear and enable.
  - Output: a tick pulse on wrap.
  - Instantiated once.

## Test plan

Parameters for all scenarios: CLK_HZ=10, PERIOD_SEC=3, SEG_COUNT=4, CNT_W=4.

- Basic round:
  - Stimulus: gameSig at cycle 5.
  - Expected: startGen at cycle 6. timeLeft goes 3→2→1→0 at 10-cycle intervals. stopGen pulses exactly 30 cycles after startGen, and answerSig rises with it.
- Symbol shifting:
  - Stimulus: symbols 0xA1, 0xB2, 0xC3, 0xD4, 0xE5 in RUN; the 2nd and 5th are special.
  - Expected: gameSegs = {B2, C3, D4, E5} from digit 3 down to digit 0, and numSpecial = 2.
- Saturation:
  - Stimulus: 20 special symbols in one round.
  - Expected: numSpecial holds at 15.
- Answer check:
  - Stimulus: answerVal = 2 with numSpecial = 2.
  - Expected: resultValid and resultOk = 1 next cycle. Repeating with answerVal = 3 gives resultOk = 0.
- Boundaries:
  - Stimulus: symValid on the last RUN cycle and on the first ANSWER cycle.
  - Expected: only the first is counted.
  - Stimulus: gameSig during RUN.
  - Expected: no startGen, and the timer is unaffected.
- Reset and pause:
  - Stimulus: Rst mid-RUN.
  - Expected: IDLE next cycle, with all digits = 0x01 and numSpecial = 0.
  - With GAME_ROUND_PAUSE_EN, stimulus: pause for 7 cycles during RUN.
  - Expected: stopGen arrives 37 cycles after startGen, and genHold is high for those 7 cycles.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game round controller.
// Holds the FSM state encoding, the blank digit pattern and the helper that
// sizes the seconds-remaining counter.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        ANSWER = 2'd2
    } state_t;

    // Digit pattern shown after a clear (segment "a" only).
    localparam logic [7:0] SEG_BLANK_DEFAULT = 8'h01;

    // Bits needed to hold 0..period_sec; never less than one bit.
    function automatic int tl_width(input int period_sec);
        return (period_sec < 1) ? 1 : $clog2(period_sec + 1);
    endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Signal bundle between the round controller and its neighbours
// (start button logic, symbol generator, answer entry, display driver).
// Optional macro GAME_ROUND_PAUSE_EN adds the pause input and genHold output.
//
// Handshake semantics: every *Valid / *Sig input is a one-cycle strobe with no
// ready back-pressure; a strobe is consumed on the rising edge where it is high
// if the controller is in the state that accepts it, otherwise it is dropped.
// Output pulses (startGen, stopGen, resultValid) are high for exactly one cycle.
interface game_round_ctrl_if
    import game_pkg::*;
#(
    parameter int PERIOD_SEC = 15,
    parameter int SEG_COUNT  = 4,
    parameter int SYM_W      = 8,
    parameter int CNT_W      = 8
);
    localparam int TL_W = tl_width(PERIOD_SEC);

    logic                       gameSig;
    logic                       symValid;
    logic                       symSpecial;
    logic [SYM_W-1:0]           symData;
    logic                       answerValid;
    logic [CNT_W-1:0]           answerVal;
    logic                       startGen;
    logic                       stopGen;
    logic                       answerSig;
    logic                       resultValid;
    logic                       resultOk;
    logic [CNT_W-1:0]           numSpecial;
    logic [TL_W-1:0]            timeLeft;
    logic [SEG_COUNT*SYM_W-1:0] gameSegs;
    state_t                     dbgState;
`ifdef GAME_ROUND_PAUSE_EN
    logic                       pause;
    logic                       genHold;

    modport slave (
        input  gameSig, symValid, symSpecial, symData, answerValid, answerVal, pause,
        output startGen, stopGen, answerSig, resultValid, resultOk, numSpecial,
               timeLeft, gameSegs, dbgState, genHold
    );
    modport master (
        output gameSig, symValid, symSpecial, symData, answerValid, answerVal, pause,
        input  startGen, stopGen, answerSig, resultValid, resultOk, numSpecial,
               timeLeft, gameSegs, dbgState, genHold
    );
`else
    modport slave (
        input  gameSig, symValid, symSpecial, symData, answerValid, answerVal,
        output startGen, stopGen, answerSig, resultValid, resultOk, numSpecial,
               timeLeft, gameSegs, dbgState
    );
    modport master (
        output gameSig, symValid, symSpecial, symData, answerValid, answerVal,
        input  startGen, stopGen, answerSig, resultValid, resultOk, numSpecial,
               timeLeft, gameSegs, dbgState
    );
`endif

endinterface

// File: rtl/game_prescaler.sv
// Seconds prescaler: counts enabled cycles 0..CLK_HZ-1 and flags the wrap.
// tick_o is high during the enabled cycle whose edge wraps the count.
module game_prescaler #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic Clk100M,
    input  logic Rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);
    localparam int            PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] count_q;

    assign tick_o = enable_i && (count_q == LAST);

    // Cycle counter; clear wins over counting so a new round always starts at 0.
    always_ff @(posedge Clk100M) begin
        if (Rst || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= tick_o ? '0 : count_q + PW'(1);
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Game round controller: times a round of PERIOD_SEC seconds, shifts incoming
// symbols into the display digits, counts special symbols and then judges the
// player's answer against that count.
// Optional macro GAME_ROUND_PAUSE_EN adds a pause input that freezes the round
// timer and symbol intake while in RUN, reported on genHold.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int               CLK_HZ     = 100_000_000,
    parameter int               PERIOD_SEC = 15,
    parameter int               SEG_COUNT  = 4,
    parameter int               SYM_W      = 8,
    parameter int               CNT_W      = 8,
    parameter logic [SYM_W-1:0] SEG_BLANK  = SYM_W'(SEG_BLANK_DEFAULT)
) (
    input  logic            Clk100M,
    input  logic            Rst,
    game_round_ctrl_if.slave bus
);
    localparam int                  TL_W        = tl_width(PERIOD_SEC);
    localparam int                  SEGS_W      = SEG_COUNT * SYM_W;
    localparam logic [TL_W-1:0]     PERIOD_LOAD = TL_W'(PERIOD_SEC);
    localparam logic [TL_W-1:0]     TL_ONE      = TL_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [SEGS_W-1:0]   BLANK_ALL   = {SEG_COUNT{SEG_BLANK}};

    state_t              state_q;
    logic                startGen_q;
    logic                stopGen_q;
    logic                answerSig_q;
    logic                resultValid_q;
    logic                resultOk_q;
    logic [CNT_W-1:0]    numSpecial_q;
    logic [CNT_W-1:0]    numSpecial_d;
    logic [TL_W-1:0]     timeLeft_q;
    logic [SEGS_W-1:0]   segs_q;
    logic [SEGS_W-1:0]   segs_d;

    logic                paused;
    logic                start_req;
    logic                run_en;
    logic                sym_take;
    logic                sec_tick;

`ifdef GAME_ROUND_PAUSE_EN
    assign paused      = bus.pause;
    assign bus.genHold = (state_q == RUN) && bus.pause;
`else
    assign paused      = 1'b0;
`endif

    assign start_req = (state_q == IDLE) && bus.gameSig;
    assign run_en    = (state_q == RUN) && !paused;
    assign sym_take  = run_en && bus.symValid;

    game_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .Clk100M  (Clk100M),
        .Rst      (Rst),
        .clear_i  (start_req),
        .enable_i (run_en),
        .tick_o   (sec_tick)
    );

    // Next digit window and saturating special count for an accepted symbol.
    always_comb begin
        segs_d       = segs_q;
        numSpecial_d = numSpecial_q;
        if (sym_take) begin
            for (int i = SEG_COUNT - 1; i > 0; i--) begin
                segs_d[i*SYM_W +: SYM_W] = segs_q[(i-1)*SYM_W +: SYM_W];
            end
            segs_d[SYM_W-1:0] = bus.symData;
            if (bus.symSpecial && (numSpecial_q != CNT_MAX)) begin
                numSpecial_d = numSpecial_q + CNT_W'(1);
            end
        end
    end

    // Round FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            state_q       <= IDLE;
            startGen_q    <= 1'b0;
            stopGen_q     <= 1'b0;
            answerSig_q   <= 1'b0;
            resultValid_q <= 1'b0;
            resultOk_q    <= 1'b0;
            numSpecial_q  <= '0;
            timeLeft_q    <= '0;
            segs_q        <= BLANK_ALL;
        end else begin
            startGen_q    <= 1'b0;
            stopGen_q     <= 1'b0;
            resultValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.gameSig) begin
                        state_q      <= RUN;
                        numSpecial_q <= '0;
                        timeLeft_q   <= PERIOD_LOAD;
                        segs_q       <= BLANK_ALL;
                        startGen_q   <= 1'b1;
                    end
                end
                RUN: begin
                    segs_q       <= segs_d;
                    numSpecial_q <= numSpecial_d;
                    if (sec_tick) begin
                        timeLeft_q <= timeLeft_q - TL_ONE;
                        if (timeLeft_q == TL_ONE) begin
                            state_q     <= ANSWER;
                            stopGen_q   <= 1'b1;
                            answerSig_q <= 1'b1;
                        end
                    end
                end
                ANSWER: begin
                    if (bus.answerValid) begin
                        resultOk_q    <= (bus.answerVal == numSpecial_q);
                        resultValid_q <= 1'b1;
                        answerSig_q   <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.startGen    = startGen_q;
    assign bus.stopGen     = stopGen_q;
    assign bus.answerSig   = answerSig_q;
    assign bus.resultValid = resultValid_q;
    assign bus.resultOk    = resultOk_q;
    assign bus.numSpecial  = numSpecial_q;
    assign bus.timeLeft    = timeLeft_q;
    assign bus.gameSegs    = segs_q;
    assign bus.dbgState    = state_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with CLK_HZ=10, PERIOD_SEC=3,
// SEG_COUNT=4, SYM_W=8, CNT_W=4. Pause scenario runs when GAME_ROUND_PAUSE_EN
// is defined.
module tb_game_round_ctrl;
    import game_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    game_round_ctrl_if #(
        .PERIOD_SEC (3),
        .SEG_COUNT  (4),
        .SYM_W      (8),
        .CNT_W      (4)
    ) bus ();

    game_round_ctrl #(
        .CLK_HZ     (10),
        .PERIOD_SEC (3),
        .SEG_COUNT  (4),
        .SYM_W      (8),
        .CNT_W      (4),
        .SEG_BLANK  (8'h01)
    ) dut (
        .Clk100M (clk),
        .Rst     (rst),
        .bus     (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n cycles, leaving time 1 unit after the last rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle symbol strobe.
    task automatic send_sym(input logic [7:0] d, input logic sp);
        bus.symValid   = 1'b1;
        bus.symData    = d;
        bus.symSpecial = sp;
        step(1);
        bus.symValid   = 1'b0;
        bus.symSpecial = 1'b0;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        bus.gameSig     = 1'b0;
        bus.symValid    = 1'b0;
        bus.symSpecial  = 1'b0;
        bus.symData     = 8'h00;
        bus.answerValid = 1'b0;
        bus.answerVal   = 4'd0;
`ifdef GAME_ROUND_PAUSE_EN
        bus.pause       = 1'b0;
`endif

        // Reset state
        step(3);
        check("rst_state",   bus.dbgState,    IDLE);
        check("rst_start",   bus.startGen,    1'b0);
        check("rst_stop",    bus.stopGen,     1'b0);
        check("rst_ans",     bus.answerSig,   1'b0);
        check("rst_rvalid",  bus.resultValid, 1'b0);
        check("rst_rok",     bus.resultOk,    1'b0);
        check("rst_nspec",   bus.numSpecial,  4'd0);
        check("rst_tleft",   bus.timeLeft,    2'd0);
        check("rst_segs",    bus.gameSegs,    32'h01010101);
        rst = 1'b0;
        step(2);

        // Round 1: start, k=0 is the startGen cycle
        bus.gameSig = 1'b1;
        step(1);
        bus.gameSig = 1'b0;
        check("r1_start",    bus.startGen,    1'b1);
        check("r1_state",    bus.dbgState,    RUN);
        check("r1_tl3",      bus.timeLeft,    2'd3);
        step(1);
        check("r1_start_pulse", bus.startGen, 1'b0);
        // Symbols at k=1..5; 2nd and 5th special
        send_sym(8'hA1, 1'b0);
        check("r1_sym1",     bus.gameSegs,    32'h010101A1);
        send_sym(8'hB2, 1'b1);
        send_sym(8'hC3, 1'b0);
        send_sym(8'hD4, 1'b0);
        send_sym(8'hE5, 1'b1);
        check("r1_segs5",    bus.gameSegs,    32'hB2C3D4E5);
        check("r1_nspec2",   bus.numSpecial,  4'd2);
        step(3);   // k=9
        check("r1_tl3_k9",   bus.timeLeft,    2'd3);
        step(1);   // k=10
        check("r1_tl2_k10",  bus.timeLeft,    2'd2);
        // gameSig in RUN is ignored
        bus.gameSig = 1'b1;
        step(1);   // k=11
        bus.gameSig = 1'b0;
        check("r1_nostart",  bus.startGen,    1'b0);
        check("r1_run_k11",  bus.dbgState,    RUN);
        check("r1_tl2_k11",  bus.timeLeft,    2'd2);
        step(9);   // k=20
        check("r1_tl1_k20",  bus.timeLeft,    2'd1);
        step(9);   // k=29, last RUN cycle
        check("r1_nostop29", bus.stopGen,     1'b0);
        check("r1_run_k29",  bus.dbgState,    RUN);
        send_sym(8'hF6, 1'b1);   // last RUN cycle: accepted, k=30
        check("r1_stop30",   bus.stopGen,     1'b1);
        check("r1_ans30",    bus.answerSig,   1'b1);
        check("r1_state30",  bus.dbgState,    ANSWER);
        check("r1_tl0",      bus.timeLeft,    2'd0);
        check("r1_nspec3",   bus.numSpecial,  4'd3);
        check("r1_segs_last", bus.gameSegs,   32'hC3D4E5F6);
        send_sym(8'h07, 1'b1);   // first ANSWER cycle: dropped, k=31
        check("r1_nspec_drop", bus.numSpecial, 4'd3);
        check("r1_segs_drop", bus.gameSegs,   32'hC3D4E5F6);
        check("r1_stop_pulse", bus.stopGen,   1'b0);
        check("r1_ans31",    bus.answerSig,   1'b1);
        // Correct answer
        bus.answerValid = 1'b1;
        bus.answerVal   = 4'd3;
        step(1);
        bus.answerValid = 1'b0;
        check("r1_rvalid",   bus.resultValid, 1'b1);
        check("r1_rok",      bus.resultOk,    1'b1);
        check("r1_idle",     bus.dbgState,    IDLE);
        check("r1_ans_fall", bus.answerSig,   1'b0);
        check("r1_hold_ns",  bus.numSpecial,  4'd3);
        check("r1_hold_seg", bus.gameSegs,    32'hC3D4E5F6);

        // Round 2 back-to-back: gameSig in the resultValid cycle
        bus.gameSig = 1'b1;
        step(1);   // k=0
        bus.gameSig = 1'b0;
        check("r2_start",    bus.startGen,    1'b1);
        check("r2_nspec0",   bus.numSpecial,  4'd0);
        check("r2_blank",    bus.gameSegs,    32'h01010101);
        check("r2_tl3",      bus.timeLeft,    2'd3);
        check("r2_rvalid0",  bus.resultValid, 1'b0);
        check("r2_rok_held", bus.resultOk,    1'b1);
        // 20 special symbols: saturation at 15
        for (int i = 0; i < 20; i++) begin
            send_sym(8'h10 + 8'(i), 1'b1);
        end        // k=20
        check("r2_sat",      bus.numSpecial,  4'd15);
        check("r2_segs",     bus.gameSegs,    32'h20212223);
        check("r2_tl1",      bus.timeLeft,    2'd1);
        step(9);   // k=29
        check("r2_run29",    bus.dbgState,    RUN);
        step(1);   // k=30
        check("r2_stop30",   bus.stopGen,     1'b1);
        // Answer outside ANSWER was tested implicitly; now a wrong answer
        bus.answerValid = 1'b1;
        bus.answerVal   = 4'd3;
        step(1);
        bus.answerValid = 1'b0;
        check("r2_rvalid",   bus.resultValid, 1'b1);
        check("r2_rok0",     bus.resultOk,    1'b0);
        step(1);
        check("r2_rvalid_pulse", bus.resultValid, 1'b0);
        check("r2_rok_hold", bus.resultOk,    1'b0);

        // Strobes in IDLE are ignored
        bus.answerValid = 1'b1;
        bus.answerVal   = 4'd15;
        send_sym(8'h99, 1'b1);
        bus.answerValid = 1'b0;
        check("idle_no_rv",  bus.resultValid, 1'b0);
        check("idle_rok",    bus.resultOk,    1'b0);
        check("idle_segs",   bus.gameSegs,    32'h20212223);
        check("idle_ns",     bus.numSpecial,  4'd15);

        // Round 3: reset mid-RUN
        bus.gameSig = 1'b1;
        step(1);
        bus.gameSig = 1'b0;
        step(4);
        send_sym(8'h5A, 1'b1);
        check("r3_ns1",      bus.numSpecial,  4'd1);
        rst = 1'b1;
        step(1);
        check("r3_idle",     bus.dbgState,    IDLE);
        check("r3_blank",    bus.gameSegs,    32'h01010101);
        check("r3_ns0",      bus.numSpecial,  4'd0);
        check("r3_tl0",      bus.timeLeft,    2'd0);
        check("r3_ans0",     bus.answerSig,   1'b0);
        rst = 1'b0;
        step(1);

`ifdef GAME_ROUND_PAUSE_EN
        // Round 4: pause 7 cycles in RUN stretches the round to 37 cycles
        bus.pause = 1'b1;
        #1;
        check("p_idle_hold", bus.genHold,     1'b0);
        bus.pause   = 1'b0;
        bus.gameSig = 1'b1;
        step(1);   // k=0
        bus.gameSig = 1'b0;
        check("p_start",     bus.startGen,    1'b1);
        step(4);   // k=4
        for (int i = 0; i < 7; i++) begin
            bus.pause      = 1'b1;
            bus.symValid   = 1'b1;
            bus.symSpecial = 1'b1;
            bus.symData    = 8'h77;
            #1;
            check("p_hold",  bus.genHold,     1'b1);
            step(1);
        end        // k=11
        bus.pause      = 1'b0;
        bus.symValid   = 1'b0;
        bus.symSpecial = 1'b0;
        #1;
        check("p_hold_off",  bus.genHold,     1'b0);
        check("p_ns0",       bus.numSpecial,  4'd0);
        check("p_blank",     bus.gameSegs,    32'h01010101);
        step(25);  // k=36
        check("p_nostop36",  bus.stopGen,     1'b0);
        check("p_run36",     bus.dbgState,    RUN);
        step(1);   // k=37
        check("p_stop37",    bus.stopGen,     1'b1);
        bus.pause = 1'b1;
        #1;
        check("p_ans_hold",  bus.genHold,     1'b0);
        bus.pause = 1'b0;
        step(1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
